// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through FIFO.
// Sticky framing/overrun flags; shares clock and reset with the Nios II system.
//
// state  | meaning
// S_IDLE | line idle, waiting for a falling edge on rxd_s
// S_START| counting to mid start bit, rejects glitches
// S_DATA | sampling 8 data bits LSB first, one per 16 ticks
// S_STOP | waiting for mid stop bit; high pushes, low flags framing
// S_BREAK| stop bit was low, waiting for the line to return high
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overrun,
    input  logic                          clear_err
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    rx_state_t state, state_nxt;

    logic          rxd_m, rxd_s, rxd_q;
    logic          fall;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    sub_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          push_pend;

    logic          tick_restart;
    logic          sub_clr;
    logic          shift_en;
    logic          stop_ok;
    logic          stop_bad;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full;
    logic          pop;
    logic          wr;
    logic          ovr_set;

    // Synchroniser plus one extra flop for start-edge detection
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_q <= rxd_s;
        end
    end

    assign fall = rxd_q & ~rxd_s;
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tick_cnt <= '0;
        end else if (tick_restart || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_restart = 1'b0;
        sub_clr      = 1'b0;
        shift_en     = 1'b0;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    tick_restart = 1'b1;
                    sub_clr      = 1'b1;
                    state_nxt    = S_START;
                end
            end
            S_START: begin
                if (tick && sub_cnt == 4'd7) begin
                    sub_clr   = 1'b1;
                    state_nxt = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && sub_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    sub_clr  = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick && sub_cnt == 4'd15) begin
                    if (rxd_s) begin
                        stop_ok   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxd_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sub_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            push_pend <= 1'b0;
        end else begin
            if (sub_clr) begin
                sub_cnt <= '0;
            end else if (tick) begin
                sub_cnt <= sub_cnt + 4'd1;
            end
            if (tick_restart) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shift_reg <= {rxd_s, shift_reg[7:1]};
            end
            // shift_reg stays stable through the push cycle that follows
            push_pend <= stop_ok;
        end
    end

    assign full    = (fifo_count == FULL_CNT);
    assign pop     = rd_en && rd_valid;
    assign wr      = push_pend && (!full || pop);
    assign ovr_set = push_pend && full && !pop;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = (fifo_count != '0);

    // A new error in the same cycle as clear_err keeps the flag set
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (stop_bad) begin
                framing_err <= 1'b1;
            end else if (clear_err) begin
                framing_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default-rate instance for the 432 clk/bit case and a fast
// instance (4 clk/tick) checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CLK_D  = 50000000;
    localparam int CLK_F  = 7372800;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 16;
    localparam int DIV_D  = CLK_D / (BAUD * 16);
    localparam int DIV_F  = CLK_F / (BAUD * 16);
    localparam int BIT_D  = 16 * DIV_D;
    localparam int BIT_F  = 16 * DIV_F;
    // Start bit driven after edge c0: sync takes edges c0+1,c0+2, START entered at c0+3,
    // stop bit sampled 8+16*9 ticks later; the byte lands one edge after that.
    localparam int STOP_OFS = 3 + 152 * DIV_F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd_f = 1'b1;
    logic       rxd_d = 1'b1;
    logic       rd_en = 1'b0;
    logic       clear_err = 1'b0;
    logic       rd_en_d = 1'b0;
    logic       clear_err_d = 1'b0;

    logic [7:0] rd_data_f, rd_data_d;
    logic       rd_valid_f, rd_valid_d;
    logic [4:0] fifo_count_f, fifo_count_d;
    logic       framing_err_f, framing_err_d;
    logic       overrun_f, overrun_d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ferr = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_pop, m_full, m_push, m_fset, m_oset;
    logic [7:0] m_pdat;

    bit rand_en = 1'b0;
    int rd_mod = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_HZ(CLK_F), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .rxd           (rxd_f),
        .rd_en         (rd_en),
        .rd_data       (rd_data_f),
        .rd_valid      (rd_valid_f),
        .fifo_count    (fifo_count_f),
        .framing_err   (framing_err_f),
        .overrun       (overrun_f),
        .clear_err     (clear_err)
    );

    uart_rx_fifo dut_d (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .rxd           (rxd_d),
        .rd_en         (rd_en_d),
        .rd_data       (rd_data_d),
        .rd_valid      (rd_valid_d),
        .fifo_count    (fifo_count_d),
        .framing_err   (framing_err_d),
        .overrun       (overrun_d),
        .clear_err     (clear_err_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus sticky flags, advanced once per clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            evq.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            cyc++;
            m_push = 1'b0;
            m_fset = 1'b0;
            m_oset = 1'b0;
            m_pdat = '0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                if (evq[0].ok) begin
                    m_push = 1'b1;
                    m_pdat = evq[0].data;
                end else begin
                    m_fset = 1'b1;
                end
                void'(evq.pop_front());
            end
            m_full = (mq.size() == DEPTH);
            m_pop  = rd_en && (mq.size() > 0);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (!m_full || m_pop) mq.push_back(m_pdat);
                else m_oset = 1'b1;
            end
            if (m_fset) m_ferr = 1'b1;
            else if (clear_err) m_ferr = 1'b0;
            if (m_oset) m_ovr = 1'b1;
            else if (clear_err) m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("m_valid", rd_valid_f, (mq.size() != 0));
            check("m_count", fifo_count_f, mq.size());
            check("m_ferr", framing_err_f, m_ferr);
            check("m_ovr", overrun_f, m_ovr);
            if (mq.size() != 0) check("m_data", rd_data_f, mq[0]);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_en) begin
            rd_en = (rd_mod != 0) ? ($urandom_range(rd_mod - 1, 0) == 0) : 1'b0;
            clear_err = ($urandom_range(299, 0) == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit def, input logic v);
        if (def) rxd_d = v;
        else rxd_f = v;
    endtask

    task automatic send_frame(input bit def, input logic [7:0] b, input int stop_low);
        int  bitc;
        ev_t e;
        bitc = def ? BIT_D : BIT_F;
        @(posedge clk);
        #1;
        if (!def) begin
            e.cyc  = cyc + STOP_OFS + ((stop_low == 0) ? 1 : 0);
            e.data = b;
            e.ok   = (stop_low == 0);
            evq.push_back(e);
        end
        drive(def, 1'b0);
        wait_cyc(bitc);
        for (int i = 0; i < 8; i++) begin
            drive(def, b[i]);
            wait_cyc(bitc);
        end
        if (stop_low == 0) begin
            drive(def, 1'b1);
            wait_cyc(bitc);
        end else begin
            drive(def, 1'b0);
            wait_cyc(stop_low * bitc);
            drive(def, 1'b1);
            wait_cyc(bitc);
        end
    endtask

    task automatic read_byte(input logic [7:0] exp, input string nm);
        @(posedge clk);
        #1;
        check({nm, "_valid"}, rd_valid_f, 1'b1);
        check(nm, rd_data_f, exp);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
    endtask

    initial begin
        int c;
        wait_cyc(3);
        check("rst_data", rd_data_f, 8'h00);
        check("rst_valid", rd_valid_f, 1'b0);
        check("rst_count", fifo_count_f, 0);
        check("rst_ferr", framing_err_f, 1'b0);
        check("rst_ovr", overrun_f, 1'b0);
        check("rst_count_d", fifo_count_d, 0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Default rate, 432 clocks per bit
        send_frame(1'b1, 8'hA5, 0);
        check("t1_valid", rd_valid_d, 1'b1);
        check("t1_data", rd_data_d, 8'hA5);
        check("t1_count", fifo_count_d, 1);
        check("t1_ferr", framing_err_d, 1'b0);
        check("t1_ovr", overrun_d, 1'b0);

        // Fill to 16, 17th byte overruns and is lost
        for (int i = 0; i <= 16; i++) send_frame(1'b0, 8'(i), 0);
        check("t2_count", fifo_count_f, 16);
        check("t2_ovr", overrun_f, 1'b1);
        check("t2_ferr", framing_err_f, 1'b0);
        for (int i = 0; i < 16; i++) read_byte(8'(i), "t2_rd");
        check("t2_empty_count", fifo_count_f, 0);
        check("t2_empty_valid", rd_valid_f, 1'b0);
        read_pop_empty: begin
            @(posedge clk); #1; rd_en = 1'b1;
            @(posedge clk); #1; rd_en = 1'b0;
        end
        check("t2_pop_empty", fifo_count_f, 0);
        pulse_clear();
        check("t2_ovr_clr", overrun_f, 1'b0);

        // Stop bit low for two bit times
        send_frame(1'b0, 8'h3C, 2);
        check("t3_ferr", framing_err_f, 1'b1);
        check("t3_count", fifo_count_f, 0);
        send_frame(1'b0, 8'h55, 0);
        check("t3_count2", fifo_count_f, 1);
        check("t3_ferr_sticky", framing_err_f, 1'b1);
        read_byte(8'h55, "t3_rd");
        pulse_clear();
        check("t3_ferr_clr", framing_err_f, 1'b0);
        // clear_err held across a framing error: flag is set for one cycle then cleared
        @(posedge clk); #1; clear_err = 1'b1;
        send_frame(1'b0, 8'h3C, 1);
        clear_err = 1'b0;
        wait_cyc(1);
        check("t3_clr_hold", framing_err_f, 1'b0);

        // Short low glitch, shorter than half a bit
        @(posedge clk); #1; rxd_f = 1'b0;
        wait_cyc(BIT_F / 2 - 8);
        rxd_f = 1'b1;
        wait_cyc(3 * BIT_F);
        check("t4_count", fifo_count_f, 0);
        check("t4_ferr", framing_err_f, 1'b0);
        check("t4_ovr", overrun_f, 1'b0);
        send_frame(1'b0, 8'h5A, 0);
        read_byte(8'h5A, "t4_rd");

        // Full FIFO, pop coincides with push of 0x77
        for (int i = 0; i < 16; i++) send_frame(1'b0, 8'hA0 + 8'(i), 0);
        check("t5_full", fifo_count_f, 16);
        fork
            send_frame(1'b0, 8'h77, 0);
            begin
                @(posedge clk); #1;
                c = cyc;
                while (cyc < c + STOP_OFS) begin
                    @(posedge clk); #1;
                end
                rd_en = 1'b1;
                @(posedge clk); #1;
                rd_en = 1'b0;
            end
        join
        check("t5_count", fifo_count_f, 16);
        check("t5_ovr", overrun_f, 1'b0);
        for (int i = 1; i < 16; i++) read_byte(8'hA0 + 8'(i), "t5_rd");
        read_byte(8'h77, "t5_last");
        check("t5_empty", fifo_count_f, 0);

        // Reset in the middle of a frame
        send_frame(1'b0, 8'h12, 0);
        @(posedge clk); #1; rxd_f = 1'b0;
        wait_cyc(BIT_F);
        rxd_f = 1'b1;
        wait_cyc(3 * BIT_F + 10);
        rst_n = 1'b0;
        wait_cyc(3);
        check("t6_rst_count", fifo_count_f, 0);
        check("t6_rst_valid", rd_valid_f, 1'b0);
        check("t6_rst_data", rd_data_f, 8'h00);
        check("t6_rst_count_d", fifo_count_d, 0);
        rst_n = 1'b1;
        wait_cyc(BIT_F);
        send_frame(1'b0, 8'h81, 0);
        check("t6_count", fifo_count_f, 1);
        check("t6_data", rd_data_f, 8'h81);
        check("t6_ferr", framing_err_f, 1'b0);
        read_byte(8'h81, "t6_rd");

        // Randomized traffic with random pops and clears, checked by the model
        rand_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(2, 0))
                0: rd_mod = 0;
                1: rd_mod = 400;
                default: rd_mod = 40;
            endcase
            send_frame(1'b0, 8'($urandom_range(255, 0)),
                       ($urandom_range(7, 0) == 0) ? int'($urandom_range(2, 1)) : 0);
            wait_cyc($urandom_range(BIT_F, 0));
        end
        rand_en = 1'b0;
        @(posedge clk);
        #2;
        rd_en = 1'b0;
        clear_err = 1'b0;
        wait_cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
